// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing defaults for the FIFO controller slice
package fifo_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH = 2 ** DEF_ADDR_W;
  localparam int DEF_AF_LEVEL = 14;
  localparam int DEF_AE_LEVEL = 2;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: ADDR_W-bit wrap-around pointer with reset, clear and increment
module fifo_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);
  always_ff @(posedge clk)
    if (clr || clear) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: occupancy-qualified pointer/flag sequencer for a DEPTH-entry FIFO array
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              err_clr,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              ovf,
  output logic              udf
);
  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = CW'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] AF_C = CW'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C = CW'(AE_LEVEL);
  always_comb begin
    full         = count == DEPTH_C;
    empty        = count == '0;
    almost_full  = count >= AF_C;
    almost_empty = count <= AE_C;
    wr_en        = wr_req && !full && !flush && !clr;
    rd_en        = rd_req && !empty && !flush && !clr;
  end
  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .clr   (clr),
    .clear (flush),
    .inc   (wr_en),
    .ptr   (wr_addr)
  );
  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .clr   (clr),
    .clear (flush),
    .inc   (rd_en),
    .ptr   (rd_addr)
  );
  // simultaneous accepted read and write leave occupancy unchanged
  always_ff @(posedge clk)
    if (clr || flush) count <= '0;
    else if (wr_en != rd_en) count <= wr_en ? count + 1'b1 : count - 1'b1;
  // a new error event in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk) begin
    ovf <= clr ? 1'b0 : (wr_req && full && !flush) ? 1'b1 : err_clr ? 1'b0 : ovf;
    udf <= clr ? 1'b0 : (rd_req && empty && !flush) ? 1'b1 : err_clr ? 1'b0 : udf;
  end
  always_ff @(posedge clk)
    if (!clr) assert (count <= DEPTH_C);
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Synchronous FIFO controller that sequences a DEPTH-entry storage array built from the team's edge-triggered flip-flop cells. Accepts write/read requests and qualifies them against occupancy. Drives the array's write strobe and write/read addresses, and reports full, empty, almost-full, almost-empty, occupancy count and sticky overflow/underflow errors. Sits between producer/consumer logic and the FIFO storage datapath.

Parameters:
ADDR_W, 4, address width; DEPTH = 2**ADDR_W (16 entries).
AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL.
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.

Ports:
clk  input  1  single clock, all state updates on rising edge.
clr  input  1  reset: synchronous, active-high.
flush  input  1  synchronous pointer/count clear; does not clear error flags.
err_clr  input  1  clears ovf/udf.
wr_req  input  1  producer write request.
rd_req  input  1  consumer read request.
wr_en  output  1  write strobe to storage; array captures data at wr_addr on this edge.
wr_addr  output  ADDR_W  write pointer.
rd_en  output  1  read accepted; data at rd_addr is valid this cycle.
rd_addr  output  ADDR_W  read pointer.
count  output  ADDR_W+1  occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_LEVEL.
almost_empty  output  1  count <= AE_LEVEL.
ovf  output  1  sticky: write requested while full.
udf  output  1  sticky: read requested while empty.

Behaviour:
- Reset (clr=1 at edge): wr_addr=0, rd_addr=0, count=0, ovf=0, udf=0. Hence empty=1, full=0, almost_empty=1, almost_full=0. clr overrides flush, err_clr and requests in the same cycle.
- wr_en = wr_req & ~full & ~flush & ~clr (combinational, same cycle). rd_en = rd_req & ~empty & ~flush & ~clr.
- full, empty, almost_* are combinational decodes of the registered count.
- Pointer update:
  - On a wr_en edge, wr_addr increments modulo DEPTH (DEPTH-1 -> 0).
  - On a rd_en edge, rd_addr increments modulo DEPTH.
- Count update: +1 on wr_en only; -1 on rd_en only; unchanged when both or neither.
- Latency: a written entry is readable the cycle after its wr_en edge (empty drops one cycle after the first write). There is no same-cycle write-through.
- Full with wr_req & rd_req: read accepted, write rejected, ovf set. Count goes DEPTH -> DEPTH-1.
- Empty with wr_req & rd_req: write accepted, read rejected, udf set. Count goes 0 -> 1.
- ovf is set on any edge with wr_req & full & ~flush. udf is set on any edge with rd_req & empty & ~flush.
- ovf/udf hold until err_clr or clr. If set and clear occur in the same cycle, set wins.
- flush=1: wr_addr, rd_addr and count go to 0 on that edge; requests are ignored; ovf/udf are unchanged.
- Assertion at count: count never exceeds DEPTH and never underflows.

Decomposition:
- Package fifo_pkg: ADDR_W default, DEPTH derivation, AF_LEVEL/AE_LEVEL defaults.
- One sub-module, fifo_ptr: ADDR_W-bit wrap counter with inputs clk, clr, clear (flush), inc. It is instantiated twice, for the write and read pointers.
- Count, flag decode and error logic stay in fifo_ctrl.

Test Plan:
- Reset: assert clr 2 cycles -> count=0, empty=1, full=0, almost_empty=1, wr_addr=rd_addr=0, ovf=udf=0.
- Fill: 16 consecutive wr_req -> wr_addr walks 0..15 then 0, count reaches 16, almost_full rises at count=14, full=1. A 17th wr_req -> wr_en=0, ovf=1, count stays 16.
- Drain: 16 rd_req from full -> rd_addr 0..15 then 0, almost_empty rises at count=2, empty=1. Extra rd_req -> rd_en=0, udf=1. err_clr -> udf=0.
- Simultaneous: at count=5, wr_req & rd_req for 10 cycles -> count stays 5, both pointers advance 10 (mod 16). At full, both requested -> count=15, ovf=1. At empty, both requested -> count=1, udf=1.
- Wrap: write 10, read 10, write 12 -> wr_addr wraps past 15 to 6, rd_addr=10, count=12, full=0.
- Flush/reset mid-operation: at count=9 with ovf=1, assert flush while wr_req=1 -> wr_en=0, count=0, pointers=0, ovf still 1. Then assert clr together with wr_req -> wr_en=0, ovf=0.
